// File: rtl/lapido_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lapido_pkg
//   Shared definitions for the Lapido pipeline: sequencer state encoding and
//   register-index width.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
package lapido_pkg;

  localparam int REG_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/boot_pipeline_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// boot_pipeline_controller_if
//   Bios, instruction-memory and pipeline-control signals of the sequencer.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
interface boot_pipeline_controller_if #(
  parameter int ADDR_WIDTH = 32
);
  import lapido_pkg::*;

  logic                  boot_valid;
  logic [31:0]           boot_data;
  logic                  halt;
  logic                  memRead_id_ex;
  logic [REG_IDX_W-1:0]  registerFileWrite_id_ex;
  logic [REG_IDX_W-1:0]  rs_a;
  logic [REG_IDX_W-1:0]  rs_b;

  logic [ADDR_WIDTH-1:0] imem_address;
  logic [31:0]           imem_data;
  logic                  imem_we;
  logic                  imem_oe;
  logic                  rf_reset;
  logic                  enable_pc;
  logic                  if_id_write;
  logic                  id_ex_flush;
  logic [1:0]            state;

  // The sequencer side.
  modport master (
    input  boot_valid, boot_data, halt, memRead_id_ex,
           registerFileWrite_id_ex, rs_a, rs_b,
    output imem_address, imem_data, imem_we, imem_oe, rf_reset,
           enable_pc, if_id_write, id_ex_flush, state
  );

  // The processor / bios side.
  modport slave (
    output boot_valid, boot_data, halt, memRead_id_ex,
           registerFileWrite_id_ex, rs_a, rs_b,
    input  imem_address, imem_data, imem_we, imem_oe, rf_reset,
           enable_pc, if_id_write, id_ex_flush, state
  );

endinterface
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_use_detect
//   Combinational load-use hazard comparator; all 16 registers are real.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module load_use_detect
  import lapido_pkg::*;
(
  input  wire logic                 mem_read,
  input  wire logic [REG_IDX_W-1:0] rd,
  input  wire logic [REG_IDX_W-1:0] rs_a,
  input  wire logic [REG_IDX_W-1:0] rs_b,
  output logic                      hazard
);

  assign hazard = mem_read && ((rd == rs_a) || (rd == rs_b));

endmodule
`default_nettype wire

// File: rtl/boot_pipeline_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// boot_pipeline_controller
//   Copies the bios image into instruction memory, holds the register file
//   in reset, then runs the pipeline with load-use stalls and halt.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module boot_pipeline_controller
  import lapido_pkg::*;
#(
  parameter int BOOT_WORDS   = 16,
  parameter int ADDR_WIDTH   = 32,
  parameter int CLEAR_CYCLES = 4
) (
  input  wire logic                clock,
  input  wire logic                reset,
  boot_pipeline_controller_if.master bus
);

  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [ADDR_WIDTH:0] LAST_WORD  = (ADDR_WIDTH + 1)'(BOOT_WORDS - 1);
  localparam logic [CLR_W-1:0]    LAST_CLEAR = CLR_W'(CLEAR_CYCLES - 1);

  state_t                state_q, state_d;
  // One extra bit so the count can reach BOOT_WORDS without wrapping.
  logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
  logic [CLR_W-1:0]      clear_cnt_q, clear_cnt_d;
  logic [ADDR_WIDTH-1:0] imem_address_q, imem_address_d;
  logic [31:0]           imem_data_q, imem_data_d;
  logic                  imem_we_q, imem_we_d;

  logic hazard;
  logic rf_reset;
  logic imem_oe;
  logic enable_pc;
  logic if_id_write;
  logic id_ex_flush;

  load_use_detect u_load_use_detect (
    .mem_read (bus.memRead_id_ex),
    .rd       (bus.registerFileWrite_id_ex),
    .rs_a     (bus.rs_a),
    .rs_b     (bus.rs_b),
    .hazard   (hazard)
  );

  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    clear_cnt_d    = clear_cnt_q;
    imem_address_d = imem_address_q;
    imem_data_d    = imem_data_q;
    imem_we_d      = 1'b0;
    rf_reset       = 1'b1;
    imem_oe        = 1'b0;
    enable_pc      = 1'b0;
    if_id_write    = 1'b0;
    id_ex_flush    = 1'b1;

    case (state_q)
      ST_LOAD: begin
        if (bus.boot_valid) begin
          imem_we_d      = 1'b1;
          imem_address_d = word_cnt_q[ADDR_WIDTH-1:0];
          imem_data_d    = bus.boot_data;
          word_cnt_d     = word_cnt_q + 1'b1;
          if (word_cnt_q == LAST_WORD) begin
            state_d = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        if (clear_cnt_q == LAST_CLEAR) begin
          state_d = ST_RUN;
        end else begin
          clear_cnt_d = clear_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        rf_reset    = 1'b0;
        imem_oe     = 1'b1;
        // A halting instruction freezes fetch, but the bubble still follows
        // the hazard so a stalled load is not lost.
        enable_pc   = !hazard && !bus.halt;
        if_id_write = !hazard && !bus.halt;
        id_ex_flush = hazard;
        if (bus.halt) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        rf_reset = 1'b0;
        imem_oe  = 1'b1;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_LOAD;
      word_cnt_q     <= '0;
      clear_cnt_q    <= '0;
      imem_address_q <= '0;
      imem_data_q    <= '0;
      imem_we_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      clear_cnt_q    <= clear_cnt_d;
      imem_address_q <= imem_address_d;
      imem_data_q    <= imem_data_d;
      imem_we_q      <= imem_we_d;
    end
  end

  assign bus.imem_address = imem_address_q;
  assign bus.imem_data    = imem_data_q;
  assign bus.imem_we      = imem_we_q;
  assign bus.imem_oe      = imem_oe;
  assign bus.rf_reset     = rf_reset;
  assign bus.enable_pc    = enable_pc;
  assign bus.if_id_write  = if_id_write;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_boot_pipeline_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_boot_pipeline_controller
//   Self-checking bench: directed sequences, a hazard vector table and a
//   randomized run against a count-based reference model.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_boot_pipeline_controller;

  localparam int BW = 16;
  localparam int AW = 32;
  localparam int CC = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  boot_pipeline_controller_if #(.ADDR_WIDTH(AW)) bus ();

  boot_pipeline_controller #(
    .BOOT_WORDS   (BW),
    .ADDR_WIDTH   (AW),
    .CLEAR_CYCLES (CC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       mr;
    logic [3:0] rd;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       h;
    logic       e_pc;
    logic       e_ifid;
    logic       e_flush;
  } vec_t;

  vec_t vecs[8];

  // Reference model: progress expressed as counts of work done.
  int          m_written;
  int          m_cleared;
  bit          m_halted;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic bv, input logic [31:0] bd, input logic h,
                       input logic mr, input logic [3:0] rd,
                       input logic [3:0] ra, input logic [3:0] rb);
    bus.boot_valid              = bv;
    bus.boot_data               = bd;
    bus.halt                    = h;
    bus.memRead_id_ex           = mr;
    bus.registerFileWrite_id_ex = rd;
    bus.rs_a                    = ra;
    bus.rs_b                    = rb;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic model_reset();
    m_written = 0;
    m_cleared = 0;
    m_halted  = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_data    = '0;
  endtask

  function automatic int model_state();
    if (m_written < BW) return 0;
    if (m_cleared < CC) return 1;
    if (m_halted) return 3;
    return 2;
  endfunction

  task automatic model_check();
    int  st;
    bit  run;
    bit  haz;
    st  = model_state();
    run = (st == 2);
    haz = bus.memRead_id_ex &&
          (bus.registerFileWrite_id_ex == bus.rs_a || bus.registerFileWrite_id_ex == bus.rs_b);
    chk("rnd_state",   bus.state, st);
    chk("rnd_we",      bus.imem_we, m_we);
    chk("rnd_addr",    bus.imem_address, m_addr);
    chk("rnd_data",    bus.imem_data, m_data);
    chk("rnd_oe",      bus.imem_oe, st >= 2);
    chk("rnd_rf",      bus.rf_reset, st < 2);
    chk("rnd_pc",      bus.enable_pc, run && !haz && !bus.halt);
    chk("rnd_ifid",    bus.if_id_write, run && !haz && !bus.halt);
    chk("rnd_flush",   bus.id_ex_flush, run ? haz : 1'b1);
  endtask

  task automatic model_step(input bit rst);
    int st;
    st = model_state();
    if (rst) begin
      model_reset();
    end else begin
      m_we = 1'b0;
      if (st == 0) begin
        if (bus.boot_valid) begin
          m_we   = 1'b1;
          m_addr = m_written;
          m_data = bus.boot_data;
          m_written++;
        end
      end else if (st == 1) begin
        m_cleared++;
      end else if (st == 2 && bus.halt) begin
        m_halted = 1'b1;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    vecs[0] = '{1'b1, 4'd5, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 4'd5, 4'd6, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 4'd5, 4'd5, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 4'd15, 4'd15, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 4'd7, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 4'd9, 4'd8, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state
    do_reset();
    chk("rst_state", bus.state, 2'd0);
    chk("rst_we",    bus.imem_we, 1'b0);
    chk("rst_oe",    bus.imem_oe, 1'b0);
    chk("rst_rf",    bus.rf_reset, 1'b1);
    chk("rst_pc",    bus.enable_pc, 1'b0);
    chk("rst_ifid",  bus.if_id_write, 1'b0);
    chk("rst_flush", bus.id_ex_flush, 1'b1);
    chk("rst_addr",  bus.imem_address, 32'h0);
    chk("rst_data",  bus.imem_data, 32'h0);

    // Boot load, hazard inputs asserted to show they are ignored
    for (int i = 0; i < BW; i++) begin
      drive(1'b1, 32'hA000_0000 + i, 1'b1, 1'b1, 4'd3, 4'd3, 4'd3);
      tick();
      chk("load_we",   bus.imem_we, 1'b1);
      chk("load_addr", bus.imem_address, i);
      chk("load_data", bus.imem_data, 32'hA000_0000 + i);
    end
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2);

    // Clear period: exactly CC cycles of rf_reset, then RUN
    for (int k = 0; k < CC; k++) begin
      #1;
      chk("clr_state", bus.state, 2'd1);
      chk("clr_rf",    bus.rf_reset, 1'b1);
      chk("clr_pc",    bus.enable_pc, 1'b0);
      if (k == 0) chk("clr_we_last", bus.imem_we, 1'b1);
      if (k == 1) chk("clr_we_drop", bus.imem_we, 1'b0);
      tick();
    end
    #1;
    chk("run_state", bus.state, 2'd2);
    chk("run_rf",    bus.rf_reset, 1'b0);
    chk("run_pc",    bus.enable_pc, 1'b1);
    chk("run_oe",    bus.imem_oe, 1'b1);
    chk("run_addr_hold", bus.imem_address, BW - 1);

    // Hazard / halt vector table, combinational in RUN
    foreach (vecs[j]) begin
      drive(1'b0, 32'h0, vecs[j].h, vecs[j].mr, vecs[j].rd, vecs[j].ra, vecs[j].rb);
      #1;
      chk("vec_pc",    bus.enable_pc, vecs[j].e_pc);
      chk("vec_ifid",  bus.if_id_write, vecs[j].e_ifid);
      chk("vec_flush", bus.id_ex_flush, vecs[j].e_flush);
    end

    // Halt and stay halted
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 4'd1, 4'd2);
    #1;
    chk("halt_pc_now", bus.enable_pc, 1'b0);
    tick();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 32'h1234_0000 + k, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2);
      #1;
      chk("halt_state", bus.state, 2'd3);
      chk("halt_pc",    bus.enable_pc, 1'b0);
      chk("halt_flush", bus.id_ex_flush, 1'b1);
      chk("halt_we",    bus.imem_we, 1'b0);
      tick();
    end

    // Gapped load
    do_reset();
    for (int i = 0; i < 2 * BW; i++) begin
      drive((i % 2) == 0, 32'hB000_0000 + i, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2);
      tick();
      if ((i % 2) == 0) begin
        chk("gap_we",   bus.imem_we, 1'b1);
        chk("gap_addr", bus.imem_address, i / 2);
        chk("gap_data", bus.imem_data, 32'hB000_0000 + i);
      end else begin
        chk("gap_idle", bus.imem_we, 1'b0);
      end
    end
    chk("gap_state", bus.state, 2'd1);

    // Reset after 7 writes restarts at address 0
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'hC000_0000 + i, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2);
      tick();
    end
    chk("mid_addr7", bus.imem_address, 6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_we", bus.imem_we, 1'b0);
    for (int i = 0; i < BW; i++) begin
      drive(1'b1, 32'hD000_0000 + i, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2);
      tick();
      chk("mid_addr", bus.imem_address, i);
      chk("mid_data", bus.imem_data, 32'hD000_0000 + i);
    end
    chk("mid_state", bus.state, 2'd1);

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 1200; c++) begin
      bit r;
      r = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 29) == 0,
            $urandom_range(0, 1) == 1, 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      reset = r;
      #1;
      model_check();
      model_step(r);
      tick();
      reset = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/boot_pipeline_controller.md
# boot_pipeline_controller

Top-level sequencer for the Lapido pipelined processor. It loads the boot image from the bios into instruction memory, then holds the register file in reset for a fixed clear period. It then releases the program counter and the IF/ID and ID/EX pipeline registers. While running it inserts load-use stalls and stops fetch on a decoded halt. It replaces the ad-hoc `onBios`/`WE`/`OE`/`enablePC` sequencing in the processor top.

## Interface
- `BOOT_WORDS`, 16: number of 32-bit words copied from the bios; legal range 1..2^ADDR_WIDTH-1.
- `ADDR_WIDTH`, 32: instruction memory address width.
- `CLEAR_CYCLES`, 4: cycles `rf_reset` stays high after the load finishes; must be >= 1.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `boot_valid` in 1: the bios presents a word this cycle.
- `boot_data` in 32: bios word.
- `halt` in 1: the ID stage decoded a halt instruction.
- `memRead_id_ex` in 1: the instruction in EX is a load.
- `registerFileWrite_id_ex` in 4: destination register of that load.
- `rs_a`, `rs_b` in 4 each: source fields (instruction[19:16], [15:12]) of the instruction in ID.
- `imem_address` out ADDR_WIDTH: instruction memory address during load.
- `imem_data` out 32: instruction memory write data.
- `imem_we` out 1: instruction memory write strobe.
- `imem_oe` out 1: instruction memory output enable (fetch).
- `rf_reset` out 1: register file reset.
- `enable_pc` out 1: PC update enable.
- `if_id_write` out 1: IF/ID load enable.
- `id_ex_flush` out 1: forces a bubble (all control bits 0) into ID/EX.
- `state` out 2: encoded FSM state, for debug.

## Operation
States (shared encoding): LOAD=0, CLEAR=1, RUN=2, HALT=3.

- **Reset:**
  - State becomes LOAD; word counter and clear counter become 0.
  - Outputs: `imem_we`=0, `imem_oe`=0, `rf_reset`=1, `enable_pc`=0, `if_id_write`=0, `id_ex_flush`=1, `imem_address`=0, `imem_data`=0.
- **LOAD:**
  - Each cycle with `boot_valid`=1, register `imem_address`=counter, `imem_data`=`boot_data`, `imem_we`=1, then increment the counter.
  - Cycles with `boot_valid`=0 give `imem_we`=0 and leave the counter unchanged.
  - When the write of word BOOT_WORDS-1 is issued, go to CLEAR.
  - `boot_valid` after that point is ignored.
  - `halt` and all hazard inputs are ignored.
- **CLEAR:**
  - `rf_reset`=1, `imem_we`=0, `id_ex_flush`=1, `enable_pc`=0.
  - Counts CLEAR_CYCLES cycles, then goes to RUN.
- **RUN:**
  - `rf_reset`=0, `imem_oe`=1.
  - Hazard = `memRead_id_ex` && (`registerFileWrite_id_ex`==`rs_a` || `registerFileWrite_id_ex`==`rs_b`). All 16 registers are compared; there is no hardwired zero register.
  - No hazard: `enable_pc`=1, `if_id_write`=1, `id_ex_flush`=0.
  - Hazard: `enable_pc`=0, `if_id_write`=0, `id_ex_flush`=1. These are combinational from the inputs, gated by state==RUN.
  - `halt`=1 (with or without a hazard): go to HALT next edge. `enable_pc`=0 and `if_id_write`=0 in that same cycle; `id_ex_flush` follows the hazard rule.
- **HALT:**
  - `enable_pc`=0, `if_id_write`=0, `id_ex_flush`=1, `imem_oe`=1, `rf_reset`=0.
  - Exit only via `reset`.

## Timing
- The `imem_*` write outputs are registered and appear one cycle after the accepted `boot_valid`.
- The RUN-state pipeline controls are combinational, same cycle.
- Minimum load-to-run time: BOOT_WORDS + CLEAR_CYCLES cycles after reset deasserts, assuming `boot_valid` is held high.
- A load-use stall lasts exactly one cycle: the bubble advances, so `memRead_id_ex` drops on the next cycle.
- `reset` mid-LOAD, mid-CLEAR or mid-RUN restarts from LOAD at address 0 on the next edge. Partially written memory is simply overwritten.
- The word counter is ADDR_WIDTH+1 bits wide, so reaching BOOT_WORDS never wraps.

## Structure
- A shared package `lapido_pkg` holds the state encoding (LOAD/CLEAR/RUN/HALT) and the register-index width (4).
- One sub-module, `load_use_detect`, is the natural split: a combinational comparator producing `hazard`.
- The FSM and both counters stay in the top of this block.

## Test plan
- **Boot load:** reset, then `boot_valid`=1 for 16 cycles with `boot_data`=0xA000_0000+i → writes to addresses 0..15 with matching data; `imem_we` falls after the 16th write; `state`=CLEAR.
- **Gapped load:** `boot_valid` toggling 1/0 → 16 writes over 32 cycles; addresses are contiguous with no skipped or duplicated address.
- **Clear period:** after the last write → `rf_reset` high for exactly 4 cycles, then `enable_pc`=1 and `state`=RUN.
- **Load-use hazard:** in RUN, `memRead_id_ex`=1, `registerFileWrite_id_ex`=5, `rs_b`=5 → `enable_pc`=0, `if_id_write`=0, `id_ex_flush`=1 that cycle. With `rs_a`=`rs_b`=6 instead → no stall.
- **Halt:** `halt`=1 in RUN → `enable_pc`=0 from that cycle on; `state`=HALT stays put over 20 cycles even with `boot_valid`=1.
- **Reset mid-load:** reset asserted after 7 writes → next write goes to address 0; the full 16-word load then completes normally.
